// File: rtl/sb_arb_pkg.sv
// Shared types and helpers for the switchboard TX arbiters.
package sb_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} sb_arb_state_t;

    localparam int unsigned SB_DEST_W = 32;

    // Round-robin successor of idx within 0..n-1, correct for non-power-of-2 n.
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sb_tx_arbiter_rr_pick.sv
// sb_rr_pick: combinational round-robin picker, first set req at or after ptr (mod N).
module sb_rr_pick
    import sb_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_any
);

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned idx;
            idx = (32'(ptr) + k) % N;
            if (!gnt_any && req[idx]) begin
                gnt_idx = PW'(idx);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sb_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one switchboard TX stream among N requesters.
// Optional statistics ports (pkt_count, stall_cycles) under `SB_TX_ARBITER_STATS_EN.
module sb_tx_arbiter
    import sb_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 416
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*DW-1:0]        in_data,
    input  logic [N*SB_DEST_W-1:0] in_dest,
    input  logic [N-1:0]           in_last,
    input  logic [N-1:0]           in_valid,
    output logic [N-1:0]           in_ready,
    output logic [DW-1:0]          out_data,
    output logic [SB_DEST_W-1:0]   out_dest,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef SB_TX_ARBITER_STATS_EN
    ,
    output logic [N*32-1:0]        pkt_count,
    output logic [31:0]            stall_cycles
`endif
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    sb_arb_state_t state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] grant;
    logic          pick_any;
    logic          grant_valid;
    logic          accept;

    sb_rr_pick #(.N(N)) u_pick (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    always_comb begin
        grant       = (state_q == ARB_LOCKED) ? owner_q : pick_idx;
        grant_valid = (state_q == ARB_LOCKED) ? in_valid[grant] : pick_any;
        // out_valid must not look at out_ready, so the sender can be combinational too.
        out_valid   = grant_valid && !rst;
        out_data    = in_data[grant*DW +: DW];
        out_dest    = in_dest[grant*SB_DEST_W +: SB_DEST_W];
        out_last    = in_last[grant];
        accept      = out_valid && out_ready;

        in_ready        = '0;
        in_ready[grant] = accept;

        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (out_last) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = PW'(rr_wrap(32'(grant), N));
            end else if (state_q == ARB_IDLE) begin
                state_d = ARB_LOCKED;
                owner_d = grant;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef SB_TX_ARBITER_STATS_EN
    logic [N-1:0][31:0] pkt_count_q, pkt_count_d;
    logic [31:0]        stall_q, stall_d;

    always_comb begin
        pkt_count_d = pkt_count_q;
        if (accept && out_last) begin
            pkt_count_d[grant] = pkt_count_q[grant] + 32'd1;
        end
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count_q <= '0;
            stall_q     <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
            stall_q     <= stall_d;
        end
    end

    assign pkt_count    = pkt_count_q;
    assign stall_cycles = stall_q;
`endif

endmodule
